// File: rtl/reg_bank_pkg.sv
// Shared constants for the register-select interface and the register bank.
package reg_bank_pkg;
    localparam int REG_WIDTH = 16;
    localparam int REG_COUNT = 8;
    localparam int PC_INDEX  = 7;
    // Idle value for the active-low load strobes: nothing loads.
    localparam logic [REG_COUNT-1:0] REG_ONES = '1;
endpackage

// File: rtl/reg_bank_if.sv
// Register-select bus: one-hot output enables and load strobes from the
// selector, data and status back from the bank.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int COUNT = REG_COUNT
);
    logic [COUNT-1:0] regOes;
    logic [COUNT-1:0] regNotLoads;
    logic [WIDTH-1:0] dataIn;
    logic             pcInc;
    logic             errClear;
    logic [WIDTH-1:0] dataOut;
    logic             dataOutValid;
    logic [WIDTH-1:0] pcOut;
    logic             multiOeErr;
    logic             multiLoadErr;

    // Selector side.
    modport master (
        output regOes, regNotLoads, dataIn, pcInc, errClear,
        input  dataOut, dataOutValid, pcOut, multiOeErr, multiLoadErr
    );

    // Register bank side.
    modport slave (
        input  regOes, regNotLoads, dataIn, pcInc, errClear,
        output dataOut, dataOutValid, pcOut, multiOeErr, multiLoadErr
    );
endinterface

// File: rtl/reg_bank_cell.sv
// reg_cell: one register with async reset, active-low load and an optional
// increment. Load has priority over increment; increment wraps silently.
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             notLoad,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register update: load beats increment, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         q <= '0;
        else if (!notLoad) q <= d;
        else if (inc)      q <= q + WIDTH'(1);
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank at the consuming end of the register-select interface.
// Wired-OR read bus, per-register load cells, PC increment on one cell,
// and sticky flags for broken one-hot select encodings.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH     = REG_WIDTH,
    parameter int REG_COUNT = reg_bank_pkg::REG_COUNT,
    parameter int PC_INDEX  = reg_bank_pkg::PC_INDEX
) (
    input  logic     clk,
    input  logic     reset,
    reg_bank_if.slave bus
);

    logic [REG_COUNT-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]                readBus;
    logic                            multiOe;
    logic                            multiLd;
    logic                            multiOeErrQ;
    logic                            multiLoadErrQ;

    // Only the PC cell sees pcInc; the rest have increment tied off.
    for (genvar i = 0; i < REG_COUNT; i++) begin : gCell
        reg_bank_cell #(.WIDTH(WIDTH)) uCell (
            .clk     (clk),
            .reset   (reset),
            .notLoad (bus.regNotLoads[i]),
            .inc     ((i == PC_INDEX) ? bus.pcInc : 1'b0),
            .d       (bus.dataIn),
            .q       (regs[i])
        );
    end

    // Wired-OR read bus: OR of every enabled register, zero when none.
    always_comb begin
        readBus = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (bus.regOes[i]) readBus = readBus | regs[i];
        end
    end

    assign multiOe = ($countones(bus.regOes) > 1);
    assign multiLd = ($countones(~bus.regNotLoads) > 1);

    // Sticky multi-enable flag: a fresh violation beats errClear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             multiOeErrQ <= 1'b0;
        else if (multiOe)      multiOeErrQ <= 1'b1;
        else if (bus.errClear) multiOeErrQ <= 1'b0;
    end

    // Sticky multi-load flag: a fresh violation beats errClear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             multiLoadErrQ <= 1'b0;
        else if (multiLd)      multiLoadErrQ <= 1'b1;
        else if (bus.errClear) multiLoadErrQ <= 1'b0;
    end

    assign bus.dataOut      = readBus;
    assign bus.dataOutValid = ($countones(bus.regOes) == 1);
    assign bus.pcOut        = regs[PC_INDEX];
    assign bus.multiOeErr   = multiOeErrQ;
    assign bus.multiLoadErr = multiLoadErrQ;

endmodule
